// File: rtl/conv_enc_k3.sv
// conv_enc_k3: rate-1/2 K=3 convolutional encoder with valid/ready handshakes on both sides.
// Define CONV_ENC_TAIL_EN to append two zero tail symbols per frame (trellis back to state 0).
module conv_enc_k3 #(
   parameter int         FRAME_LEN = 8,
   parameter logic [2:0] G0        = 3'b111,
   parameter logic [2:0] G1        = 3'b101
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       in_bit,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [1:0] out_pair,
   output logic       out_last
);
   localparam int FW = $clog2(FRAME_LEN) + 1;
   logic          run_q;
   logic [1:0]    sr_q, sr_d;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic          out_valid_q, out_valid_d;
   logic [1:0]    pair_q, pair_d;
   logic          last_q, last_d;
   logic          slot, load, b, fr_end;
   logic [2:0]    w;
`ifdef CONV_ENC_TAIL_EN
   typedef enum logic {DATA, TAIL} state_t;
   state_t state_q, state_d;
   logic   tcnt_q, tcnt_d, tail_go;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= DATA;
      else state_q <= state_d;
   end
   always_comb begin
      state_d = state_q;
      if (state_q == DATA && in_valid && in_ready && fr_end) state_d = TAIL;
      else if (tail_go && tcnt_q) state_d = DATA;
   end
`endif
   // run_q keeps in_ready low until the first edge after reset release
   always_comb begin
      slot     = !out_valid_q || out_ready;
      fr_end   = fcnt_q == FW'(FRAME_LEN - 1);
`ifdef CONV_ENC_TAIL_EN
      in_ready = run_q && slot && state_q == DATA;
      tail_go  = slot && state_q == TAIL;
      load     = (in_valid && in_ready) || tail_go;
      b        = tail_go ? 1'b0 : in_bit;
      w        = {b, sr_q[0], sr_q[1]};
      sr_d     = !load ? sr_q : (tail_go && tcnt_q) ? 2'b00 : {sr_q[0], b};
      fcnt_d   = (!load || tail_go) ? fcnt_q : fr_end ? '0 : fcnt_q + FW'(1);
      tcnt_d   = tail_go ? !tcnt_q : (in_valid && in_ready && fr_end) ? 1'b0 : tcnt_q;
      last_d   = load ? (tail_go && tcnt_q) : last_q;
`else
      in_ready = run_q && slot;
      load     = in_valid && in_ready;
      b        = in_bit;
      w        = {b, sr_q[0], sr_q[1]};
      sr_d     = load ? {sr_q[0], b} : sr_q;
      fcnt_d   = !load ? fcnt_q : fr_end ? '0 : fcnt_q + FW'(1);
      last_d   = load ? fr_end : last_q;
`endif
      out_valid_d = load || (out_valid_q && !out_ready);
      pair_d      = load ? {^(w & G0), ^(w & G1)} : pair_q;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run_q       <= 1'b0;
         sr_q        <= 2'b00;
         fcnt_q      <= '0;
         out_valid_q <= 1'b0;
         pair_q      <= 2'b00;
         last_q      <= 1'b0;
`ifdef CONV_ENC_TAIL_EN
         tcnt_q      <= 1'b0;
`endif
      end else begin
         run_q       <= 1'b1;
         sr_q        <= sr_d;
         fcnt_q      <= fcnt_d;
         out_valid_q <= out_valid_d;
         pair_q      <= pair_d;
         last_q      <= last_d;
`ifdef CONV_ENC_TAIL_EN
         tcnt_q      <= tcnt_d;
`endif
      end
   end
   assign out_valid = out_valid_q;
   assign out_pair  = pair_q;
   assign out_last  = last_q;
endmodule

// File: tb/tb_conv_enc_k3.sv
// tb_conv_enc_k3: directed and random stimulus for conv_enc_k3 against a symbol-queue reference model.
module tb_conv_enc_k3;
   localparam int         FL  = 8;
   localparam logic [2:0] TG0 = 3'b111;
   localparam logic [2:0] TG1 = 3'b101;
`ifdef CONV_ENC_TAIL_EN
   localparam bit TAIL = 1'b1;
`else
   localparam bit TAIL = 1'b0;
`endif
   localparam logic [1:0] E1 [10] = '{2'd3, 2'd2, 2'd0, 2'd1, 2'd1, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
   logic       clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_bit = 1'b0, out_ready = 1'b0;
   logic       in_ready, out_valid, out_last;
   logic [1:0] out_pair;
   int         tests = 0, fails = 0, nacc = 0, ir_low = 0;
   bit         h1 = 1'b0, h2 = 1'b0, stall_prev = 1'b0;
   logic [1:0] stall_pair;
   logic [1:0] exp_pair [$];
   bit         exp_last [$];
   logic [1:0] obs_pair [$];
   bit         obs_last [$];

   conv_enc_k3 #(.FRAME_LEN(FL)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit),
      .out_valid(out_valid), .out_ready(out_ready), .out_pair(out_pair), .out_last(out_last)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // parity of the tapped bits, counted as a sum modulo 2
   task automatic push_sym(input bit bb, input bit last);
      int p0, p1;
      p0 = ((TG0[2] & bb) + (TG0[1] & h1) + (TG0[0] & h2)) % 2;
      p1 = ((TG1[2] & bb) + (TG1[1] & h1) + (TG1[0] & h2)) % 2;
      exp_pair.push_back({1'(p0), 1'(p1)});
      exp_last.push_back(last);
      h2 = h1;
      h1 = bb;
   endtask

   task automatic model_accept(input bit bb);
      nacc++;
      push_sym(bb, !TAIL && (nacc % FL == 0));
      if (TAIL && nacc == FL) begin
         push_sym(1'b0, 1'b0);
         push_sym(1'b0, 1'b1);
         h1 = 1'b0;
         h2 = 1'b0;
         nacc = 0;
      end
   endtask

   task automatic cycle(input bit v, input bit bb, input bit r, output bit acc);
      in_valid = v;
      in_bit = bb;
      out_ready = r;
      @(negedge clk);
      if (stall_prev) begin
         check("stall_valid", 32'(out_valid), 32'd1);
         check("stall_pair", 32'(out_pair), 32'(stall_pair));
      end
      stall_prev = out_valid && !out_ready;
      stall_pair = out_pair;
      if (!in_ready) ir_low++;
      if (out_valid && out_ready) begin
         obs_pair.push_back(out_pair);
         obs_last.push_back(out_last);
         if (exp_pair.size() == 0) check("spurious_symbol", 32'd1, 32'd0);
         else begin
            check("pair", 32'(out_pair), 32'(exp_pair.pop_front()));
            check("last", 32'(out_last), 32'(exp_last.pop_front()));
         end
      end
      acc = in_valid && in_ready;
      if (acc) model_accept(in_bit);
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input logic [15:0] bits, input int n, input bit r);
      int i = 0, k = 0;
      bit a;
      while (i < n && k < 200) begin
         cycle(1'b1, bits[i], r, a);
         if (a) i++;
         k++;
      end
      check("feed_done", 32'(i), 32'(n));
   endtask

   task automatic flush(input int n);
      bit a;
      repeat (n) cycle(1'b0, 1'b0, 1'b1, a);
   endtask

   task automatic do_reset;
      in_valid = 1'b0;
      out_ready = 1'b0;
      rst = 1'b0;
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_pair", 32'(out_pair), 32'd0);
      check("rst_out_last", 32'(out_last), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      exp_pair.delete();
      exp_last.delete();
      h1 = 1'b0;
      h2 = 1'b0;
      nacc = 0;
      stall_prev = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;
      check("ready_after_reset", 32'(in_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit a;
      int k, nl;
      #2;
      do_reset();
      // reference vector 1,0,1,1,0,0,0,0
      obs_pair.delete(); obs_last.delete(); ir_low = 0;
      feed(16'h000D, FL, 1'b1);
      flush(4);
      check("v1_in_ready_low", 32'(ir_low), 32'(TAIL ? 2 : 0));
      check("v1_nsym", 32'(obs_pair.size()), 32'(TAIL ? 10 : 8));
      for (int i = 0; i < obs_pair.size() && i < 10; i++) begin
         check($sformatf("v1_pair%0d", i), 32'(obs_pair[i]), 32'(E1[i]));
         check($sformatf("v1_last%0d", i), 32'(obs_last[i]), 32'(i == (TAIL ? 9 : 7)));
      end
      // impulse response
      obs_pair.delete(); obs_last.delete();
      feed(16'h0001, FL, 1'b1);
      flush(4);
      check("imp_nsym", 32'(obs_pair.size()), 32'(TAIL ? 10 : 8));
      if (obs_pair.size() >= 3) begin
         check("imp0", 32'(obs_pair[0]), 32'd3);
         check("imp1", 32'(obs_pair[1]), 32'd2);
         check("imp2", 32'(obs_pair[2]), 32'd3);
      end
      // backpressure mid-frame
      feed(16'($urandom), 4, 1'b1);
      ir_low = 0;
      repeat (5) cycle(1'b1, 1'(($urandom)), 1'b0, a);
      check("bp_in_ready_low", 32'(ir_low), 32'd5);
      feed(16'($urandom), FL - 4, 1'b1);
      flush(4);
      // reset after 3 accepted bits, then 1,0,1,1
      feed(16'h0005, 3, 1'b1);
      do_reset();
      obs_pair.delete(); obs_last.delete();
      feed(16'h000D, 4, 1'b1);
      flush(2);
      check("rr_nsym", 32'(obs_pair.size()), 32'd4);
      if (obs_pair.size() >= 4) begin
         check("rr0", 32'(obs_pair[0]), 32'd3);
         check("rr1", 32'(obs_pair[1]), 32'd2);
         check("rr2", 32'(obs_pair[2]), 32'd0);
         check("rr3", 32'(obs_pair[3]), 32'd1);
      end
      feed(16'($urandom), FL - 4, 1'b1);
      flush(4);
      // back-to-back frames with in_valid held high
      obs_pair.delete(); obs_last.delete();
      feed(16'($urandom), 2 * FL, 1'b1);
      flush(4);
      check("b2b_nsym", 32'(obs_pair.size()), 32'(TAIL ? 2 * (FL + 2) : 2 * FL));
      nl = 0;
      foreach (obs_last[i]) nl += int'(obs_last[i]);
      check("b2b_nlast", 32'(nl), 32'd2);
      if (obs_last.size() == (TAIL ? 2 * (FL + 2) : 2 * FL)) begin
         check("b2b_last_a", 32'(obs_last[TAIL ? FL + 1 : FL - 1]), 32'd1);
         check("b2b_last_b", 32'(obs_last[TAIL ? 2 * FL + 3 : 2 * FL - 1]), 32'd1);
      end
      // random traffic with random backpressure
      repeat (400) cycle(1'($urandom_range(0, 1)), 1'($urandom), $urandom_range(0, 3) != 0, a);
      k = 0;
      while (exp_pair.size() > 0 && k < 50) begin
         cycle(1'b0, 1'b0, 1'b1, a);
         k++;
      end
      check("drain_empty", 32'(exp_pair.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
